// File: rtl/arbitro_memoria_dados.sv
// Arbiter sharing one single-port data memory between the CPU load/store path
// and a debug/loader port. Accesses are serialised through IDLE/ISSUE/WAIT/DONE
// and the memory read latency (RD_LAT cycles, 1..15) is absorbed in WAIT.
module arbitro_memoria_dados #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned RD_LAT   = 2,
    parameter int unsigned CPU_PRIO = 1
) (
    input  logic              clock,
    input  logic              reset,
    // CPU control-unit port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    // debug/loader port
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_done,
    output logic [DATA_W-1:0] dbg_rdata,
    // data memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_t;

    state_t             state;
    port_t              winner;
    port_t              last_winner;
    logic               lat_we;
    logic [CNT_W-1:0]   wait_cnt;
    port_t              pick_c;

    // Winner selection for the current IDLE cycle (only consumed in IDLE)
    always_comb begin
        pick_c = PORT_CPU;
        if (cpu_req && dbg_req) begin
            if (CPU_PRIO != 0) begin
                pick_c = PORT_CPU;
            end else begin
                pick_c = (last_winner == PORT_DBG) ? PORT_CPU : PORT_DBG;
            end
        end else if (dbg_req) begin
            pick_c = PORT_DBG;
        end
    end

    // Access sequencer: state, latched request and all registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            winner      <= PORT_CPU;
            last_winner <= PORT_DBG;
            lat_we      <= 1'b0;
            wait_cnt    <= '0;
            cpu_gnt     <= 1'b0;
            cpu_done    <= 1'b0;
            cpu_rdata   <= '0;
            dbg_gnt     <= 1'b0;
            dbg_done    <= 1'b0;
            dbg_rdata   <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
        end else begin
            // pulses default low every cycle
            cpu_gnt  <= 1'b0;
            dbg_gnt  <= 1'b0;
            cpu_done <= 1'b0;
            dbg_done <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (cpu_req || dbg_req) begin
                        state       <= ST_ISSUE;
                        busy        <= 1'b1;
                        winner      <= pick_c;
                        last_winner <= pick_c;
                        mem_en      <= 1'b1;
                        if (pick_c == PORT_CPU) begin
                            cpu_gnt   <= 1'b1;
                            lat_we    <= cpu_we;
                            mem_we    <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                        end else begin
                            dbg_gnt   <= 1'b1;
                            lat_we    <= dbg_we;
                            mem_we    <= dbg_we;
                            mem_addr  <= dbg_addr;
                            mem_wdata <= dbg_wdata;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (lat_we) begin
                        state <= ST_DONE;
                        if (winner == PORT_CPU) begin
                            cpu_done <= 1'b1;
                        end else begin
                            dbg_done <= 1'b1;
                        end
                    end else begin
                        state    <= ST_WAIT;
                        wait_cnt <= CNT_W'(RD_LAT - 1);
                    end
                end

                ST_WAIT: begin
                    // the last WAIT cycle is the one in which mem_rdata is valid
                    if (wait_cnt == '0) begin
                        state <= ST_DONE;
                        if (winner == PORT_CPU) begin
                            cpu_rdata <= mem_rdata;
                            cpu_done  <= 1'b1;
                        end else begin
                            dbg_rdata <= mem_rdata;
                            dbg_done  <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
